gobou_mac_ctrl: RTL

//  Sequencer for one gobou_mac lane during a fully-connected layer.
//  For each output neuron it issues input/weight memory read addresses and times the MAC

---
 rtl/gobou_mac_ctrl.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/gobou_mac_ctrl.sv
// gobou_mac_ctrl -- sequencer for one gobou_mac lane during a fully-connected layer.
//
// For every output neuron n the block streams N_in input/weight address pairs
// (x = in_base+i, w = w_base+n*N_in+i). It times the MAC strobes so that they
// line up with the MAC pipeline: memory read, x/w register, pro, pro_short, accum.
// Each finished neuron sum is written to output memory at out_base+n, and done
// pulses once the whole layer has been written.
//
// Optional feature macro: GOBOU_CTRL_PAUSE_EN
//   defined   -> a 'pause' input stalls address issue while in S_ACC
//   undefined -> no pause port, and issue is never stalled
//
// Ports
//   clk, xrst           clock, synchronous active-low reset
//   start               one-cycle start request (ignored unless idle)
//   total_in/total_out  terms per neuron / neurons per layer, sampled at start
//   in_base/w_base      input / weight memory base addresses, sampled at start
//   out_base            output memory base address, sampled at start
//   qbits_in            fixed-point shift, sampled at start
//   pause               issue stall (GOBOU_CTRL_PAUSE_EN only)
//   mem_x_addr/mem_w_addr  read addresses for the input / weight memories
//   mac_qbits, mac_reset, mac_accum_we, mac_out_en   MAC controls
//   out_we/out_addr     output memory write strobe and address
//   busy/done           layer in progress / one-cycle completion pulse
module gobou_mac_ctrl #(
  parameter int DWIDTH    = 16,
  parameter int DWIDTHLOG = 4,
  parameter int AWIDTH    = 12,
  parameter int MEMLAT    = 1
) (
  input  logic                 clk,
  input  logic                 xrst,
  input  logic                 start,
  input  logic [AWIDTH-1:0]    total_in,
  input  logic [AWIDTH-1:0]    total_out,
  input  logic [AWIDTH-1:0]    in_base,
  input  logic [AWIDTH-1:0]    w_base,
  input  logic [AWIDTH-1:0]    out_base,
  input  logic [DWIDTHLOG-1:0] qbits_in,
`ifdef GOBOU_CTRL_PAUSE_EN
  input  logic                 pause,
`endif
  output logic [AWIDTH-1:0]    mem_x_addr,
  output logic [AWIDTH-1:0]    mem_w_addr,
  output logic [DWIDTHLOG-1:0] mac_qbits,
  output logic                 mac_reset,
  output logic                 mac_accum_we,
  output logic                 mac_out_en,
  output logic                 out_we,
  output logic [AWIDTH-1:0]    out_addr,
  output logic                 busy,
  output logic                 done
);

  // Cycles from an address issue to the accum_we of that term.
  localparam int D = MEMLAT + 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC   = 3'd1,
    S_GAP   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 state_r, state_s;

  // Layer configuration captured at start.
  logic [AWIDTH-1:0]      n_in_r, n_out_r, in_base_r;
  logic [DWIDTHLOG-1:0]   qbits_r, qbits_s;

  // Issue-side counters and running address pointers.
  logic [AWIDTH-1:0]      cnt_in_r, cnt_neu_r, x_addr_r, w_addr_r;

  // Write-side counter and output address.
  logic [AWIDTH-1:0]      cnt_out_r, out_addr_r;

  // Term-valid and last-term shift registers that track issues through the MAC.
  logic [D-1:0]           vpipe_r, lpipe_r;

  logic                   reset_r, out_en_r, out_we_r, busy_r, done_r;

  logic                   stall_s, issue_s, last_term_s, last_neu_s;
  logic                   accept_s, zero_cfg_s;

`ifdef GOBOU_CTRL_PAUSE_EN
  assign stall_s = pause;
`else
  assign stall_s = 1'b0;
`endif

  assign last_term_s = (cnt_in_r  == n_in_r  - AWIDTH'(1));
  assign last_neu_s  = (cnt_neu_r == n_out_r - AWIDTH'(1));
  assign accept_s    = (state_r == S_IDLE) && start;
  assign zero_cfg_s  = (total_in == {AWIDTH{1'b0}}) || (total_out == {AWIDTH{1'b0}});

  // Clamp the requested shift to the datapath width before it reaches the MAC.
  always_comb begin
    qbits_s = qbits_in;
    if (int'(qbits_in) > DWIDTH - 1) begin
      qbits_s = DWIDTHLOG'(DWIDTH - 1);
    end else begin
      qbits_s = qbits_in;
    end
  end

  // Next-state logic and per-cycle issue decision.
  always_comb begin
    state_s = state_r;
    issue_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (zero_cfg_s) begin
            state_s = S_DONE;
          end else begin
            state_s = S_ACC;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ACC: begin
        if (stall_s) begin
          state_s = S_ACC;
        end else begin
          issue_s = 1'b1;
          if (last_term_s) begin
            // The one-cycle gap keeps the next neuron's first accum_we clear of
            // the reset that closes this neuron.
            if (last_neu_s) begin
              state_s = S_DRAIN;
            end else begin
              state_s = S_GAP;
            end
          end else begin
            state_s = S_ACC;
          end
        end
      end
      S_GAP: begin
        state_s = S_ACC;
      end
      S_DRAIN: begin
        // The layer ends only when the final neuron's result has been written.
        if (out_we_r && (cnt_out_r == n_out_r - AWIDTH'(1))) begin
          state_s = S_DONE;
        end else begin
          state_s = S_DRAIN;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State register, strobe pipelines, counters and address pointers.
  always_ff @(posedge clk) begin
    if (!xrst) begin
      state_r    <= S_IDLE;
      n_in_r     <= {AWIDTH{1'b0}};
      n_out_r    <= {AWIDTH{1'b0}};
      in_base_r  <= {AWIDTH{1'b0}};
      qbits_r    <= {DWIDTHLOG{1'b0}};
      cnt_in_r   <= {AWIDTH{1'b0}};
      cnt_neu_r  <= {AWIDTH{1'b0}};
      x_addr_r   <= {AWIDTH{1'b0}};
      w_addr_r   <= {AWIDTH{1'b0}};
      cnt_out_r  <= {AWIDTH{1'b0}};
      out_addr_r <= {AWIDTH{1'b0}};
      vpipe_r    <= {D{1'b0}};
      lpipe_r    <= {D{1'b0}};
      reset_r    <= 1'b0;
      out_en_r   <= 1'b0;
      out_we_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r  <= state_s;
      busy_r   <= (state_s == S_ACC) || (state_s == S_GAP) || (state_s == S_DRAIN);
      done_r   <= (state_s == S_DONE);

      // A stalled cycle shifts a 0 in, leaving a hole in the accum_we stream.
      vpipe_r  <= {vpipe_r[D-2:0], issue_s};
      lpipe_r  <= {lpipe_r[D-2:0], issue_s & last_term_s};

      // out_en and reset land one cycle after the last term's accum_we, so y
      // captures the finished sum on the same edge that accum clears.
      out_en_r <= lpipe_r[D-1];
      reset_r  <= lpipe_r[D-1] | (accept_s & ~zero_cfg_s);
      out_we_r <= out_en_r;

      if (accept_s) begin
        n_in_r     <= total_in;
        n_out_r    <= total_out;
        in_base_r  <= in_base;
        qbits_r    <= qbits_s;
        cnt_in_r   <= {AWIDTH{1'b0}};
        cnt_neu_r  <= {AWIDTH{1'b0}};
        x_addr_r   <= in_base;
        w_addr_r   <= w_base;
        cnt_out_r  <= {AWIDTH{1'b0}};
        out_addr_r <= out_base;
      end else begin
        if (issue_s) begin
          // The weight pointer runs straight through all neurons (n*N_in+i),
          // so no multiplier is needed; only x rewinds per neuron.
          w_addr_r <= w_addr_r + AWIDTH'(1);
          if (last_term_s) begin
            cnt_in_r <= {AWIDTH{1'b0}};
            x_addr_r <= in_base_r;
          end else begin
            cnt_in_r <= cnt_in_r + AWIDTH'(1);
            x_addr_r <= x_addr_r + AWIDTH'(1);
          end
        end
        if (state_r == S_GAP) begin
          cnt_neu_r <= cnt_neu_r + AWIDTH'(1);
        end
        if (out_we_r) begin
          cnt_out_r  <= cnt_out_r + AWIDTH'(1);
          out_addr_r <= out_addr_r + AWIDTH'(1);
        end
      end
    end
  end

  assign mem_x_addr   = x_addr_r;
  assign mem_w_addr   = w_addr_r;
  assign mac_qbits    = qbits_r;
  assign mac_reset    = reset_r;
  assign mac_accum_we = vpipe_r[D-1];
  assign mac_out_en   = out_en_r;
  assign out_we       = out_we_r;
  assign out_addr     = out_addr_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule
